// File: rtl/exec_sequencer.sv
// Multi-cycle execution sequencer for the 9-bit core: Start/Ack program handshake,
// gating of decoder write/branch enables, load/store stretching and a cycle counter.
module exec_sequencer #(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt,
    input  logic             BranchEn,
    input  logic             Taken,
    input  logic             RegWriteEn,
    input  logic             MemWriteEn,
    input  logic             MemReadEn,
    output logic             PCInit,
    output logic             PCEn,
    output logic             PCLoad,
    output logic             RegWriteGate,
    output logic             MemWriteGate,
    output logic             Ack,
    output logic             Busy,
    output logic [CNT_W-1:0] CycleCount
);

    // state     | meaning
    // S_IDLE    | waiting for Start, everything off
    // S_INIT    | one cycle: load PC with program start, counter restarts at 1
    // S_RUN     | executing one instruction per cycle
    // S_MEMWAIT | load/store in flight, PC frozen until WaitCnt reaches 1
    // S_DONE    | program finished, Ack held until the next Start
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_RUN     = 3'd2,
        S_MEMWAIT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [3:0] LP_WAIT_LOAD = 4'(MEM_LAT - 1);
    localparam logic       LP_STRETCH   = (MEM_LAT > 1);

    state_t           r_state;
    logic [3:0]       r_wait_cnt;
    logic [CNT_W-1:0] r_cycle_cnt;

    logic             w_memop;
    logic             w_run_stall;
    logic             w_wait_last;
    logic [CNT_W-1:0] w_cnt_next;

    logic w_pcinit;
    logic w_pcen;
    logic w_pcload;
    logic w_regw_gate;
    logic w_memw_gate;
    logic w_ack;
    logic w_busy;

    assign w_memop     = MemReadEn | MemWriteEn;
    assign w_run_stall = Halt | (w_memop & LP_STRETCH);
    assign w_wait_last = (r_wait_cnt <= 4'd1);
    assign w_cnt_next  = (&r_cycle_cnt) ? r_cycle_cnt : r_cycle_cnt + CNT_W'(1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= '0;
            r_cycle_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) r_state <= S_INIT;
                end
                S_INIT: begin
                    r_cycle_cnt <= CNT_W'(1);
                    r_state     <= S_RUN;
                end
                S_RUN: begin
                    r_cycle_cnt <= w_cnt_next;
                    if (Halt) begin
                        r_state <= S_DONE;
                    end else if (w_memop && LP_STRETCH) begin
                        r_wait_cnt <= LP_WAIT_LOAD;
                        r_state    <= S_MEMWAIT;
                    end
                end
                S_MEMWAIT: begin
                    r_cycle_cnt <= w_cnt_next;
                    if (w_wait_last) begin
                        r_wait_cnt <= '0;
                        r_state    <= S_RUN;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    if (Start) r_state <= S_INIT;
                end
                default: begin
                    r_wait_cnt <= '0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    // Mealy decode: gates follow the decoder inputs in the same cycle.
    always_comb begin
        w_pcinit    = 1'b0;
        w_pcen      = 1'b0;
        w_pcload    = 1'b0;
        w_regw_gate = 1'b0;
        w_memw_gate = 1'b0;
        w_ack       = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_INIT: begin
                w_pcinit = 1'b1;
                w_busy   = 1'b1;
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (!w_run_stall) begin
                    w_pcen      = 1'b1;
                    w_pcload    = BranchEn & Taken;
                    w_regw_gate = RegWriteEn & ~BranchEn & ~MemWriteEn;
                    w_memw_gate = MemWriteEn;
                end
            end
            S_MEMWAIT: begin
                w_busy = 1'b1;
                if (w_wait_last) begin
                    w_pcen      = 1'b1;
                    w_pcload    = BranchEn & Taken;
                    w_regw_gate = MemReadEn & RegWriteEn;
                    w_memw_gate = MemWriteEn;
                end
            end
            S_DONE: begin
                w_ack = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // Reset masks every output immediately so a pending store can never escape.
    assign PCInit       = ~Reset & w_pcinit;
    assign PCEn         = ~Reset & w_pcen;
    assign PCLoad       = ~Reset & w_pcload;
    assign RegWriteGate = ~Reset & w_regw_gate;
    assign MemWriteGate = ~Reset & w_memw_gate;
    assign Ack          = ~Reset & w_ack;
    assign Busy         = ~Reset & w_busy;
    assign CycleCount   = Reset ? '0 : r_cycle_cnt;

endmodule
